// File: rtl/sobel_edge_filter.sv
// Sobel edge detector: converts three buffered RGB444 rows to gray, keeps a 3x3 window and
// emits a thresholded edge pixel three clocks later, with line/frame markers carried along.
module sobel_edge_filter #(
  parameter int WIDTH  = 640,
  parameter int THRESH = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_line_start,
  input  logic        in_frame_start,
  input  logic [11:0] row0_pixel,
  input  logic [11:0] row1_pixel,
  input  logic [11:0] row2_pixel,
  output logic [11:0] pixel_out,
  output logic        out_valid,
  output logic        out_line_start,
  output logic        out_frame_start
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_WIDTH  = CW'(WIDTH);
  localparam logic [8:0]    C_THRESH = 9'(THRESH);

  function automatic logic [5:0] gray_of(input logic [11:0] p);
    return {2'b00, p[11:8]} + {1'b0, p[7:4], 1'b0} + {2'b00, p[3:0]};
  endfunction

  // Operand is a two's-complement 9-bit gradient in -240..240.
  function automatic logic [8:0] abs9(input logic [8:0] v);
    return v[8] ? (9'd0 - v) : v;
  endfunction

  logic [5:0]    r_win [0:2][0:2];
  logic [CW-1:0] r_col_cnt;
  logic [1:0]    r_row_cnt;
  logic          r_v1, r_blank1, r_ls1, r_fs1;
  logic          r_v2, r_blank2, r_ls2, r_fs2;
  logic [8:0]    r_gx, r_gy;

  logic [CW-1:0] w_idx, w_col_nxt;
  logic [1:0]    w_row_nxt;
  logic          w_blank;
  logic [8:0]    w_sum_r, w_sum_l, w_sum_b, w_sum_t;
  logic [8:0]    w_mag;

  // Column index of the incoming pixel and next column/row counter values.
  always_comb begin
    w_idx     = r_col_cnt;
    w_col_nxt = r_col_cnt;
    w_row_nxt = r_row_cnt;
    if (in_line_start) begin
      w_idx     = {CW{1'b0}};
      w_col_nxt = CW'(1);
    end else if (r_col_cnt < C_WIDTH) begin
      w_col_nxt = r_col_cnt + CW'(1);
    end else begin
      w_col_nxt = C_WIDTH;
    end
    if (in_frame_start) begin
      w_row_nxt = 2'd0;
    end else if (in_line_start && (r_row_cnt < 2'd2)) begin
      w_row_nxt = r_row_cnt + 2'd1;
    end else begin
      w_row_nxt = r_row_cnt;
    end
    w_blank = (w_idx < CW'(2)) || (w_row_nxt < 2'd2);
  end

  // Stage 1: window shift, counters and per-pixel control bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= 6'd0;
        end
      end
      r_col_cnt <= {CW{1'b0}};
      r_row_cnt <= 2'd0;
      r_v1      <= 1'b0;
      r_blank1  <= 1'b0;
      r_ls1     <= 1'b0;
      r_fs1     <= 1'b0;
    end else begin
      r_v1     <= in_valid;
      r_blank1 <= w_blank;
      r_ls1    <= in_valid & in_line_start;
      r_fs1    <= in_valid & in_frame_start;
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= gray_of(row0_pixel);
        r_win[1][2] <= gray_of(row1_pixel);
        r_win[2][2] <= gray_of(row2_pixel);
        r_col_cnt   <= w_col_nxt;
        r_row_cnt   <= w_row_nxt;
      end
    end
  end

  // Weighted column/row sums; differences wrap correctly into 9-bit two's complement.
  always_comb begin
    w_sum_r = {3'b000, r_win[0][2]} + {2'b00, r_win[1][2], 1'b0} + {3'b000, r_win[2][2]};
    w_sum_l = {3'b000, r_win[0][0]} + {2'b00, r_win[1][0], 1'b0} + {3'b000, r_win[2][0]};
    w_sum_b = {3'b000, r_win[2][0]} + {2'b00, r_win[2][1], 1'b0} + {3'b000, r_win[2][2]};
    w_sum_t = {3'b000, r_win[0][0]} + {2'b00, r_win[0][1], 1'b0} + {3'b000, r_win[0][2]};
  end

  // Stage 2: gradients.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gx     <= 9'd0;
      r_gy     <= 9'd0;
      r_v2     <= 1'b0;
      r_blank2 <= 1'b0;
      r_ls2    <= 1'b0;
      r_fs2    <= 1'b0;
    end else begin
      r_gx     <= w_sum_r - w_sum_l;
      r_gy     <= w_sum_b - w_sum_t;
      r_v2     <= r_v1;
      r_blank2 <= r_blank1;
      r_ls2    <= r_ls1;
      r_fs2    <= r_fs1;
    end
  end

  assign w_mag = abs9(r_gx) + abs9(r_gy);

  // Stage 3: magnitude compare and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_out       <= 12'h000;
      out_valid       <= 1'b0;
      out_line_start  <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      pixel_out       <= (r_v2 && !r_blank2 && (w_mag >= C_THRESH)) ? 12'hFFF : 12'h000;
      out_valid       <= r_v2;
      out_line_start  <= r_ls2;
      out_frame_start <= r_fs2;
    end
  end

endmodule
